// File: rtl/icache_refill_if.sv
// Memory read port of the instruction-cache refill engine.
// Carries a single-burst read-address channel (arvalid/arready/araddr/arlen)
// and its read-data channel (rvalid/rready/rdata/rlast/rerr).
//   master : refill engine side (drives address, arlen and rready)
//   slave  : memory side (drives arready and the data beats)
interface icache_refill_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int BEAT_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic [BEAT_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  rerr;

  modport master (
    output arvalid, araddr, arlen, rready,
    input  arready, rvalid, rdata, rlast, rerr
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rvalid, rdata, rlast, rerr
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine.
// On a fetch miss, issues one read burst for the block-aligned address,
// gathers BEAT_COUNT beats into a block and writes it into the cache with a
// single-cycle strobe. A bad burst (error beat or misplaced/missing rlast)
// is still drained in full, then reported with a one-cycle o_error pulse
// instead of the cache write.
// Ports:
//   i_clk, i_arst_n   clock, async active-low reset
//   i_miss, i_addr    miss request and fetch address (sampled in IDLE only)
//   o_busy            refill in progress
//   mem               memory read port (master side)
//   o_cache_we/addr/block  cache write strobe, aligned address, block
//   o_error           refill aborted
module icache_refill #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int BEAT_WIDTH  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_miss,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic                   o_busy,
  icache_refill_if.master        mem,
  output logic                   o_cache_we,
  output logic [ADDR_WIDTH-1:0]  o_cache_addr,
  output logic [BLOCK_WIDTH-1:0] o_cache_block,
  output logic                   o_error
);

  localparam int BEAT_COUNT   = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int OFFSET_WIDTH = $clog2(BLOCK_WIDTH / 8);
  localparam int CNT_W        = $clog2(BEAT_COUNT);
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEAT_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;

  state_t                                 state, state_nxt;
  logic [CNT_W-1:0]                       cnt;
  logic                                   err;
  logic [ADDR_WIDTH-1:0]                  addr_q;
  logic [BEAT_COUNT-1:0][BEAT_WIDTH-1:0]  block_q;

  logic beat_fire, last_beat, ar_fire;

  assign ar_fire   = (state == ADDR) && mem.arready;
  assign beat_fire = (state == DATA) && mem.rvalid;
  assign last_beat = (cnt == LAST_BEAT);

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next state; completion is counted, rlast only feeds the error flag
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (i_miss) state_nxt = ADDR;
      ADDR:  if (ar_fire) state_nxt = DATA;
      DATA:  if (beat_fire && last_beat) state_nxt = WRITE;
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter and sticky error flag, both cleared while idle
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (beat_fire) begin
      cnt <= cnt + 1'b1;
      if (mem.rerr || (mem.rlast != last_beat)) err <= 1'b1;
    end
  end

  // Aligned address doubles as burst address and cache write address
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)                     addr_q <= '0;
    else if (state == IDLE && i_miss)  addr_q <= i_addr & ALIGN_MASK;
  end

  // One slot per beat; beat k lands at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
  for (genvar g = 0; g < BEAT_COUNT; g++) begin : g_slot
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n)                             block_q[g] <= '0;
      else if (beat_fire && cnt == CNT_W'(g))    block_q[g] <= mem.rdata;
    end
  end

  // Outputs: registers or pure state decodes
  assign o_busy        = (state != IDLE);
  assign mem.arvalid   = (state == ADDR);
  assign mem.araddr    = addr_q;
  assign mem.arlen     = 8'(BEAT_COUNT - 1);
  assign mem.rready    = (state == DATA);
  assign o_cache_we    = (state == WRITE) && !err;
  assign o_error       = (state == WRITE) && err;
  assign o_cache_addr  = addr_q;
  assign o_cache_block = block_q;

endmodule
